usb_crc16_tx_sequencer: RTL

//  Sequences one USB DATA-packet payload through crc_16_gen and the serial TX path.
//  - Fetches payload bytes from the TX FIFO and serialises them LSB-first on bit_strobe.
//  - Drives crc_16_gen clear/shift_enable/serial_in in lock-step, then appends the complemented 16-bit CRC.
//  - Sits between the bulk-transfer protocol FSM (start/abort/done) and the bit-level encoder (tx_bit).

---
 rtl/usb_crc_pkg.sv | 19 +
 rtl/tx_shift_reg.sv | 37 +++
 rtl/usb_crc16_tx_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_crc_pkg.sv
// Shared types and constants for the USB CRC16 TX sequencer.
// Contents: FSM state enum, CRC width, CRC inversion mask, largest payload.
// Imported by the sequencer top and its shift-register sub-module.
package usb_crc_pkg;

  localparam int              CRC_WIDTH       = 16;
  localparam logic [15:0]     CRC_RESIDUE_INV = 16'hFFFF;
  localparam int              MAX_PKT_BYTES   = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_SHIFT = 3'd3,
    ST_CRC   = 3'd4,
    ST_DONE  = 3'd5
  } tx_seq_state_t;

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, shift-right register with LSB serial output.
// Ports: clk/n_rst, load + load_val (load wins over shift), shift, serial_out = bit 0.
// Latency: load/shift take effect on the next rising edge; serial_out is registered.
module tx_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  output logic             serial_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = {1'b0, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign serial_out = data_q[0];

endmodule

// File: rtl/usb_crc16_tx_sequencer.sv
// Sequences one USB DATA payload LSB-first onto tx_bit, driving crc_16_gen in lock-step, then the 16-bit CRC.
// Ports: start/byte_count/abort control, bit_strobe tick, FIFO valid/ready byte input, crc_16_gen byte inputs
//   and clear/shift/serial outputs, tx_bit/tx_bit_valid to the encoder, busy/done/error status.
// Latency: start -> crc_clear next clk; last CRC strobe -> done next clk; FIFO stalls by holding fifo_ready in FETCH.
module usb_crc16_tx_sequencer
  import usb_crc_pkg::*;
#(
  parameter int MAX_BYTES  = MAX_PKT_BYTES,
  parameter bit INVERT_CRC = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [6:0] byte_count,
  input  logic       abort,
  input  logic       bit_strobe,
  input  logic [7:0] fifo_data,
  input  logic       fifo_valid,
  output logic       fifo_ready,
  input  logic [7:0] crc_gen_1,
  input  logic [7:0] crc_gen_2,
  output logic       crc_clear,
  output logic       crc_shift_en,
  output logic       crc_serial_in,
  output logic       tx_bit,
  output logic       tx_bit_valid,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [7:0]           MAX_LEN = 8'(MAX_BYTES);
  localparam logic [CRC_WIDTH-1:0] CRC_XOR = INVERT_CRC ? CRC_RESIDUE_INV : {CRC_WIDTH{1'b0}};

  tx_seq_state_t state_q, state_d;
  logic [6:0]    count_q, count_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;

  logic                 sr_load;
  logic                 sr_shift;
  logic [CRC_WIDTH-1:0] sr_load_val;
  logic                 sr_out;

  logic                 start_ok;
  logic [CRC_WIDTH-1:0] crc_val;
  logic                 crc_bit;

  assign start_ok = start && ({1'b0, byte_count} <= MAX_LEN);
  assign crc_val  = {crc_gen_2, crc_gen_1} ^ CRC_XOR;

  // Until the first CRC bit leaves, crc_16_gen is frozen (no shift, no clear),
  // so its live value is the latched CRC; the shift register only takes over
  // once the first bit is gone. This also covers a strobe on the entry cycle.
  assign crc_bit = (bit_cnt_q == 4'd0) ? crc_val[0] : sr_out;

  tx_shift_reg #(
    .WIDTH (CRC_WIDTH)
  ) u_shreg (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (sr_load),
    .load_val   (sr_load_val),
    .shift      (sr_shift),
    .serial_out (sr_out)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    bit_cnt_d   = bit_cnt_q;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          count_d = byte_count;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        bit_cnt_d = '0;
        state_d   = (count_q != 7'd0) ? ST_FETCH : ST_CRC;
      end
      ST_FETCH: begin
        // A bit time arriving with no byte loaded is an underrun.
        if (bit_strobe) begin
          state_d = ST_IDLE;
        end else if (fifo_valid) begin
          sr_load     = 1'b1;
          sr_load_val = {{(CRC_WIDTH-8){1'b0}}, fifo_data};
          bit_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_strobe) begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            count_d   = count_q - 7'd1;
            state_d   = (count_q == 7'd1) ? ST_CRC : ST_FETCH;
          end
        end
      end
      ST_CRC: begin
        if (bit_strobe) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            sr_load     = 1'b1;
            sr_load_val = {1'b0, crc_val[CRC_WIDTH-1:1]};
          end else begin
            sr_shift = 1'b1;
          end
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sr_load   = 1'b0;
      sr_shift  = 1'b0;
    end
  end

  // Outputs. Pulses are suppressed in an abort cycle so an abandoned packet
  // never reports done/error and never clears or advances crc_16_gen.
  always_comb begin
    fifo_ready    = 1'b0;
    crc_clear     = 1'b0;
    crc_shift_en  = 1'b0;
    crc_serial_in = 1'b0;
    tx_bit        = 1'b0;
    tx_bit_valid  = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    busy          = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        error = start && !start_ok && !abort;
      end
      ST_CLEAR: begin
        crc_clear = !abort;
      end
      ST_FETCH: begin
        // Underrun wins over a simultaneous byte: do not consume it.
        fifo_ready = !bit_strobe;
        error      = bit_strobe && !abort;
      end
      ST_SHIFT: begin
        if (bit_strobe && !abort) begin
          tx_bit        = sr_out;
          tx_bit_valid  = 1'b1;
          crc_serial_in = sr_out;
          crc_shift_en  = 1'b1;
        end
      end
      ST_CRC: begin
        if (bit_strobe && !abort) begin
          tx_bit       = crc_bit;
          tx_bit_valid = 1'b1;
        end
      end
      ST_DONE: begin
        done = !abort;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
